// File: rtl/dsbpm_axi_pkg.sv
// Shared AXI constants, beat sizing helpers and readout FSM states
// for the DDR record readout engine.
package dsbpm_axi_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_FINISH
  } rd_state_e;

  function automatic int beat_bytes(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int size_log2(input int data_width);
    return $clog2(data_width / 8);
  endfunction
endpackage

// File: rtl/dsbpm_ddr_readout_axis_out_reg.sv
// One-stage valid/ready output register for the readout stream;
// holds a single beat of tdata/tlast until the consumer takes it.
module axis_out_reg
  import dsbpm_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic                  i_ready,
  output logic                  o_can_load,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last
);
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;

  assign o_can_load = !r_valid || i_ready;
  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_last     = r_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end
endmodule

// File: rtl/dsbpm_ddr_readout.sv
// AXI4 read engine: fetches recorded DDR records in INCR bursts
// and streams them out through a one-stage AXI-Stream register.
module dsbpm_ddr_readout
  import dsbpm_axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 35,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int BURST_BEATS    = 16,
  parameter int COUNT_WIDTH    = 24
) (
  input  logic                      sysClk,
  input  logic                      sysReset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [AXI_ADDR_WIDTH-1:0] baseAddr,
  input  logic [COUNT_WIDTH-1:0]    beatCount,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [COUNT_WIDTH-1:0]    beatsRead,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready
);
  localparam int BEAT_BYTES = beat_bytes(AXI_DATA_WIDTH);
  localparam int SIZE_LOG2  = size_log2(AXI_DATA_WIDTH);
  localparam int ALIGN_BITS = $clog2(BURST_BEATS * BEAT_BYTES);
  localparam logic [COUNT_WIDTH-1:0] LP_BURST = COUNT_WIDTH'(BURST_BEATS);
  localparam logic [COUNT_WIDTH-1:0] LP_ONE   = COUNT_WIDTH'(1);

  rd_state_e                 r_state;
  rd_state_e                 w_next;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [COUNT_WIDTH-1:0]    r_req_remain;
  logic [COUNT_WIDTH-1:0]    r_burst_left;
  logic [COUNT_WIDTH-1:0]    r_beats;
  logic                      r_error;
  logic                      r_drain;

  logic [COUNT_WIDTH-1:0]    w_burst;
  logic [7:0]                w_arlen;
  logic [AXI_ADDR_WIDTH-1:0] w_step;
  logic                      w_misalign;
  logic                      w_burst_end;
  logic                      w_beat_err;
  logic                      w_last_in;
  logic                      w_start_ok;
  logic                      w_arvalid;
  logic                      w_ar_hs;
  logic                      w_rready;
  logic                      w_r_hs;
  logic                      w_load;
  logic                      w_done;
  logic                      w_can_load;
  logic                      w_tvalid;

  assign w_burst     = (r_req_remain >= LP_BURST) ? LP_BURST : r_req_remain;
  assign w_arlen     = 8'(w_burst - LP_ONE);
  assign w_step      = AXI_ADDR_WIDTH'(w_burst) << SIZE_LOG2;
  assign w_misalign  = baseAddr[ALIGN_BITS-1:0] != '0;
  assign w_burst_end = r_burst_left == LP_ONE;
  assign w_beat_err  = (m_axi_rresp != AXI_RESP_OKAY) ||
                       (m_axi_rlast != w_burst_end);
  // Last beat of the run: nothing left to request and this burst ends.
  assign w_last_in   = (r_req_remain == '0) && w_burst_end;

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_start_ok = 1'b0;
    w_arvalid  = 1'b0;
    w_ar_hs    = 1'b0;
    w_rready   = 1'b0;
    w_r_hs     = 1'b0;
    w_load     = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_ok = 1'b1;
          if (w_misalign || beatCount == '0) w_next = ST_FINISH;
          else                               w_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        w_arvalid = 1'b1;
        w_ar_hs   = m_axi_arready;
        if (m_axi_arready) w_next = ST_DATA;
        else if (abort)    w_next = ST_FINISH;
      end
      ST_DATA: begin
        w_rready = r_drain || w_can_load;
        w_r_hs   = w_rready && m_axi_rvalid;
        w_load   = w_r_hs && !r_drain;
        if (w_r_hs && w_burst_end) begin
          if (r_req_remain != '0 && !r_drain && !abort &&
              !r_error && !w_beat_err)
            w_next = ST_ADDR;
          else
            w_next = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (!w_tvalid) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      r_addr       <= '0;
      r_req_remain <= '0;
      r_burst_left <= '0;
      r_beats      <= '0;
      r_error      <= 1'b0;
      r_drain      <= 1'b0;
    end else begin
      if (w_tvalid && m_axis_tready) r_beats <= r_beats + LP_ONE;
      if (w_start_ok) begin
        r_addr       <= baseAddr;
        r_req_remain <= beatCount;
        r_beats      <= '0;
        r_error      <= w_misalign;
        r_drain      <= 1'b0;
      end
      if (w_ar_hs) begin
        r_addr       <= r_addr + w_step;
        r_req_remain <= r_req_remain - w_burst;
        r_burst_left <= w_burst;
      end
      if (w_r_hs) begin
        r_burst_left <= r_burst_left - LP_ONE;
        if (w_beat_err) r_error <= 1'b1;
      end
      // An accepted burst must still be drained once abort is seen.
      if ((r_state == ST_DATA || w_ar_hs) && abort) r_drain <= 1'b1;
    end
  end

  axis_out_reg #(
    .DATA_WIDTH(AXI_DATA_WIDTH)
  ) u_out (
    .i_clk     (sysClk),
    .i_rst     (sysReset),
    .i_load    (w_load),
    .i_data    (m_axi_rdata),
    .i_last    (w_last_in),
    .i_ready   (m_axis_tready),
    .o_can_load(w_can_load),
    .o_valid   (w_tvalid),
    .o_data    (m_axis_tdata),
    .o_last    (m_axis_tlast)
  );

  assign busy          = r_state != ST_IDLE;
  assign done          = w_done;
  assign error         = r_error;
  assign beatsRead     = r_beats;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = w_arvalid ? w_arlen : 8'd0;
  assign m_axi_arsize  = 3'(SIZE_LOG2);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arvalid = w_arvalid;
  assign m_axi_rready  = w_rready;
  assign m_axis_tvalid = w_tvalid;
endmodule

// File: tb/tb_dsbpm_ddr_readout.sv
// Directed scoreboard bench for dsbpm_ddr_readout with a small
// AXI read slave model and an AR/stream monitor.
module tb_dsbpm_ddr_readout;
  localparam int AW = 35;
  localparam int DW = 256;
  localparam int BB = 16;
  localparam int CW = 24;

  logic          sysClk = 1'b0;
  logic          sysReset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] baseAddr = '0;
  logic [CW-1:0] beatCount = '0;
  logic          busy, done, error;
  logic [CW-1:0] beatsRead;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic          rlast = 1'b0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast;
  logic          tready = 1'b1;

  int checks = 0;
  int failures = 0;
  logic [AW+7:0] exp_ar[$];
  logic [DW:0]   exp_st[$];
  logic [AW+7:0] slv_q[$];
  int ar_seen = 0;
  int idx = 0;
  int err_idx = -1;
  int abort_idx = -1;
  int viol = 0;
  bit gap_mode = 1'b0;
  bit toggle_mode = 1'b0;
  bit ar_slow = 1'b0;

  always #5 sysClk = ~sysClk;

  dsbpm_ddr_readout dut (
    .sysClk(sysClk), .sysReset(sysReset),
    .start(start), .abort(abort),
    .baseAddr(baseAddr), .beatCount(beatCount),
    .busy(busy), .done(done), .error(error),
    .beatsRead(beatsRead),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tlast(tlast), .m_axis_tready(tready)
  );

  function automatic logic [DW-1:0] mk(input logic [AW-1:0] a);
    logic [31:0] w;
    w = a[31:0];
    return {4{~w, w}};
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: handshakes are sampled on the falling edge.
  initial begin : mon
    logic [DW:0]   e;
    logic [AW+7:0] ea;
    forever begin
      @(negedge sysClk);
      if (rready && tvalid && !tready) viol++;
      if (tvalid && tready) begin
        check("stream_expected", DW'(exp_st.size() != 0), DW'(1));
        if (exp_st.size() != 0) begin
          e = exp_st.pop_front();
          check("stream_data", tdata, e[DW-1:0]);
          check("stream_last", DW'(tlast), DW'(e[DW]));
        end
      end
      if (arvalid && arready) begin
        ar_seen++;
        check("ar_expected", DW'(exp_ar.size() != 0), DW'(1));
        if (exp_ar.size() != 0) begin
          ea = exp_ar.pop_front();
          check("ar_addr", DW'(araddr), DW'(ea[AW+7:8]));
          check("ar_len", DW'(arlen), DW'(ea[7:0]));
        end
        slv_q.push_back({araddr, arlen});
      end
    end
  end

  // AXI read slave plus tready/arready drivers, driven 1 after rise.
  initial begin : slave
    logic [AW+7:0] b;
    logic [AW-1:0] a;
    int rem;
    bit hs;
    bit flip;
    a = '0;
    rem = 0;
    flip = 1'b0;
    forever begin
      @(negedge sysClk);
      hs = rvalid && rready;
      @(posedge sysClk);
      #1;
      abort = 1'b0;
      flip = ~flip;
      tready = toggle_mode ? flip : 1'b1;
      arready = ar_slow ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sysReset) begin
        rvalid = 1'b0;
        rem = 0;
        slv_q.delete();
      end else begin
        if (hs) begin
          rem--;
          a = a + AW'(32);
          rvalid = 1'b0;
        end
        if (!rvalid) begin
          if (rem == 0 && slv_q.size() != 0) begin
            b = slv_q.pop_front();
            a = b[AW+7:8];
            rem = int'(b[7:0]) + 1;
          end
          if (rem != 0 && !(gap_mode && $urandom_range(0, 2) == 0)) begin
            rvalid = 1'b1;
            rdata = mk(a);
            rlast = (rem == 1);
            rresp = (idx == err_idx) ? 2'b10 : 2'b00;
            if (idx == abort_idx) abort = 1'b1;
            idx++;
          end
        end
      end
    end
  end

  task automatic setup(input logic [AW-1:0] b, input int total,
                       input int deliver, input int nbursts);
    int rem;
    int len;
    logic [AW-1:0] a;
    ar_seen = 0;
    idx = 0;
    for (int i = 0; i < deliver; i++)
      exp_st.push_back({1'(i == total - 1), mk(b + AW'(i * 32))});
    rem = total;
    a = b;
    for (int j = 0; j < nbursts; j++) begin
      len = (rem >= BB) ? BB : rem;
      exp_ar.push_back({a, 8'(len - 1)});
      a = a + AW'(len * 32);
      rem -= len;
    end
  endtask

  task automatic start_run(input logic [AW-1:0] b, input logic [CW-1:0] n);
    baseAddr = b;
    beatCount = n;
    start = 1'b1;
    @(posedge sysClk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget, output int k);
    k = 0;
    do begin
      @(negedge sysClk);
      k++;
    end while (!done && k < budget);
    check({nm, "_done"}, DW'(done), DW'(1));
    check({nm, "_busy_at_done"}, DW'(busy), DW'(1));
    @(posedge sysClk);
    #1;
    check({nm, "_busy_after"}, DW'(busy), DW'(0));
  endtask

  task automatic chk_idle(input string nm);
    check({nm, "_ctrl"}, DW'({busy, done, error, arvalid, rready, tvalid, tlast}), '0);
    check({nm, "_beats"}, DW'(beatsRead), '0);
    check({nm, "_ar"}, DW'({araddr, arlen}), '0);
    check({nm, "_tdata"}, tdata, '0);
    check({nm, "_const"}, DW'({arsize, arburst}), DW'({3'd5, 2'b01}));
  endtask

  task automatic chk_end(input string nm, input int beats, input bit err,
                         input int ars);
    check({nm, "_beatsRead"}, DW'(beatsRead), DW'(beats));
    check({nm, "_error"}, DW'(error), DW'(err));
    check({nm, "_ar_count"}, DW'(ar_seen), DW'(ars));
    check({nm, "_queues"}, DW'(exp_st.size() + exp_ar.size()), '0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    repeat (3) @(posedge sysClk);
    @(negedge sysClk);
    chk_idle("reset");
    @(posedge sysClk);
    #1;
    sysReset = 1'b0;
    @(posedge sysClk);
    #1;

    // 1: 40 beats, aligned, tready high.
    setup(35'h1000, 40, 40, 3);
    start_run(35'h1000, 40);
    wait_done("t1", 400, k);
    chk_end("t1", 40, 1'b0, 3);

    // 2: tready toggling, random R gaps and AR stalls.
    toggle_mode = 1'b1;
    gap_mode = 1'b1;
    ar_slow = 1'b1;
    viol = 0;
    setup(35'h3000, 40, 40, 3);
    start_run(35'h3000, 40);
    wait_done("t2", 2000, k);
    toggle_mode = 1'b0;
    gap_mode = 1'b0;
    ar_slow = 1'b0;
    chk_end("t2", 40, 1'b0, 3);
    check("t2_rready_hold", DW'(viol), '0);
    @(posedge sysClk);
    #1;

    // 3: misaligned base, then a good run clears error.
    setup(35'h1010, 40, 0, 0);
    start_run(35'h1010, 40);
    wait_done("t3", 20, k);
    check("t3_latency", DW'(k <= 3), DW'(1));
    chk_end("t3", 0, 1'b1, 0);
    setup(35'h2000, 5, 5, 1);
    start_run(35'h2000, 5);
    check("t3_err_cleared", DW'(error), '0);
    wait_done("t3b", 200, k);
    chk_end("t3b", 5, 1'b0, 1);

    // 4: SLVERR on beat 5 of burst 1.
    err_idx = 4;
    setup(35'h4000, 40, 16, 1);
    start_run(35'h4000, 40);
    wait_done("t4", 400, k);
    err_idx = -1;
    chk_end("t4", 16, 1'b1, 1);

    // 5: abort on beat 3 of burst 2.
    abort_idx = 18;
    setup(35'h6000, 40, 19, 2);
    start_run(35'h6000, 40);
    wait_done("t5", 400, k);
    abort_idx = -1;
    chk_end("t5", 19, 1'b0, 2);

    // 7: address wraps at the top of the AXI space.
    setup(35'h7_FFFF_FE00, 20, 20, 2);
    start_run(35'h7_FFFF_FE00, 20);
    wait_done("t7", 400, k);
    chk_end("t7", 20, 1'b0, 2);

    // 6: reset mid-burst, then a zero-length run.
    setup(35'h8000, 40, 40, 3);
    start_run(35'h8000, 40);
    k = 0;
    while (beatsRead < 10 && k < 300) begin
      @(posedge sysClk);
      #1;
      k++;
    end
    check("t6_progress", DW'(k < 300), DW'(1));
    sysReset = 1'b1;
    @(negedge sysClk);
    chk_idle("t6_in_reset");
    @(posedge sysClk);
    #1;
    @(posedge sysClk);
    #1;
    sysReset = 1'b0;
    exp_st.delete();
    exp_ar.delete();
    @(negedge sysClk);
    chk_idle("t6_after_reset");
    @(posedge sysClk);
    #1;
    setup(35'h9000, 0, 0, 0);
    start_run(35'h9000, 0);
    wait_done("t6z", 10, k);
    check("t6z_latency", DW'(k), DW'(1));
    chk_end("t6z", 0, 1'b0, 0);

    repeat (4) @(posedge sysClk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
